// File: rtl/modn_sequencer.sv
// modn_sequencer: parametrised modulo-MODULUS state sequencer.
// Supports up/down stepping, synchronous clear, and a range-checked parallel
// load. It produces a wrap pulse and a load-error pulse, and carries a
// STAGES-deep registered history line of past states.
// Optional build macro MODN_SEQ_GRAY_OUT_EN adds a registered Gray-coded copy
// of the state (state_gray) and makes the history line carry Gray codes.
// Legal configuration: MODULUS in 2..2**WIDTH, STAGES >= 1.
module modn_sequencer #(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 3,
    parameter int STAGES  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      dir,
    input  logic                      clr,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_val,
    output logic [WIDTH-1:0]          state,
    output logic                      wrap,
    output logic                      load_err,
    output logic [STAGES*WIDTH-1:0]   hist
`ifdef MODN_SEQ_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0]          state_gray
`endif
);

    // Terminal value, and the modulus widened by one bit so that a
    // MODULUS of 2**WIDTH is still representable in the load range check.
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0]        state_q;
    logic [WIDTH-1:0]        state_nxt;
    logic                    wrap_q;
    logic                    wrap_nxt;
    logic                    err_q;
    logic                    err_nxt;
    logic [WIDTH-1:0]        hist_in;
    logic [STAGES*WIDTH-1:0] hist_q;

`ifdef MODN_SEQ_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_q;
    assign hist_in    = gray_q;
    assign state_gray = gray_q;
`else
    assign hist_in = state_q;
`endif

    // Next-state selection with priority clr > load > en > hold.
    // The terminal compares are explicit, so the state never relies on
    // natural overflow to wrap.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_nxt = state_q;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (clr) begin
            state_nxt = '0;
        end else if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
                state_nxt = load_val;
            end else begin
                state_nxt = LAST;
                err_nxt   = 1'b1;
            end
        end else if (en) begin
            if (!dir) begin
                if (state_q == LAST) begin
                    state_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    state_nxt = state_q + WIDTH'(1);
                end
            end else begin
                if (state_q == '0) begin
                    state_nxt = LAST;
                    wrap_nxt  = 1'b1;
                end else begin
                    state_nxt = state_q - WIDTH'(1);
                end
            end
        end
    end

    // All registers: state, pulses, and the free-running history line
    // (which ignores en, clr and load).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            // NOTE: the history line is a register array that must read 0 straight after reset, so it is reset explicitly like any other state.
            hist_q  <= '0;
`ifdef MODN_SEQ_GRAY_OUT_EN
            gray_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments here, so every stage samples its pre-edge value and the shift line behaves as a true pipeline.
            state_q <= state_nxt;
            wrap_q  <= wrap_nxt;
            err_q   <= err_nxt;
            hist_q[0 +: WIDTH] <= hist_in;
            for (int k = 1; k < STAGES; k++) begin
                hist_q[k*WIDTH +: WIDTH] <= hist_q[(k-1)*WIDTH +: WIDTH];
            end
`ifdef MODN_SEQ_GRAY_OUT_EN
            gray_q  <= to_gray(state_nxt);
`endif
        end
    end

    assign state    = state_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;
    assign hist     = hist_q;

endmodule

// File: tb/tb_modn_sequencer.sv
// Testbench for modn_sequencer. It drives a default instance (WIDTH=2,
// MODULUS=3) and a full-range instance (WIDTH=3, MODULUS=8) from shared
// stimulus. Both are checked against a behavioural model that uses plain
// modular arithmetic and a queue of past states.
module tb_modn_sequencer;

    localparam int STG = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic en, dir, clr, load;
    logic [2:0] lv;

    logic [1:0]       st0;
    logic             wr0, er0;
    logic [STG*2-1:0] h0;
    logic [2:0]       st1;
    logic             wr1, er1;
    logic [STG*3-1:0] h1;
`ifdef MODN_SEQ_GRAY_OUT_EN
    logic [1:0] g0;
    logic [2:0] g1;
`endif

    always #5 clk = ~clk;

    modn_sequencer #(.WIDTH(2), .MODULUS(3), .STAGES(STG)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(lv[1:0]), .state(st0), .wrap(wr0), .load_err(er0), .hist(h0)
`ifdef MODN_SEQ_GRAY_OUT_EN
        , .state_gray(g0)
`endif
    );

    modn_sequencer #(.WIDTH(3), .MODULUS(8), .STAGES(STG)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(lv), .state(st1), .wrap(wr1), .load_err(er1), .hist(h1)
`ifdef MODN_SEQ_GRAY_OUT_EN
        , .state_gray(g1)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int mods[2] = '{3, 8};
    int wids[2] = '{2, 3};
    int ms[2];
    int mw[2];
    int me[2];
    int mh0[$];
    int mh1[$];

    function automatic int gray(input int v);
        return v ^ (v >> 1);
    endfunction

    function automatic int hist_view(input int v);
`ifdef MODN_SEQ_GRAY_OUT_EN
        return gray(v);
`else
        return v;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; mw[i] = 0; me[i] = 0;
        end
        mh0.delete(); mh1.delete();
        for (int k = 0; k < STG; k++) begin
            mh0.push_back(0); mh1.push_back(0);
        end
    endtask

    task automatic model_step();
        int m, v;
        mh0.push_front(hist_view(ms[0])); void'(mh0.pop_back());
        mh1.push_front(hist_view(ms[1])); void'(mh1.pop_back());
        for (int i = 0; i < 2; i++) begin
            m = mods[i];
            v = (i == 0) ? int'(lv[1:0]) : int'(lv);
            mw[i] = 0;
            me[i] = 0;
            if (clr) begin
                ms[i] = 0;
            end else if (load) begin
                if (v < m) ms[i] = v;
                else begin
                    ms[i] = m - 1;
                    me[i] = 1;
                end
            end else if (en) begin
                if (!dir) begin
                    mw[i] = (ms[i] == m - 1) ? 1 : 0;
                    ms[i] = (ms[i] + 1) % m;
                end else begin
                    mw[i] = (ms[i] == 0) ? 1 : 0;
                    ms[i] = (ms[i] == 0) ? m - 1 : ms[i] - 1;
                end
            end
        end
    endtask

    function automatic logic [31:0] pack_hist(input int i);
        logic [31:0] r = '0;
        for (int k = 0; k < STG; k++) begin
            if (i == 0) r = r | (32'(mh0[k]) << (k * wids[0]));
            else        r = r | (32'(mh1[k]) << (k * wids[1]));
        end
        return r;
    endfunction

    task automatic check_all();
        check("state0", 32'(st0), 32'(ms[0]));
        check("wrap0",  32'(wr0), 32'(mw[0]));
        check("err0",   32'(er0), 32'(me[0]));
        check("hist0",  32'(h0),  pack_hist(0));
        check("state8", 32'(st1), 32'(ms[1]));
        check("wrap8",  32'(wr1), 32'(mw[1]));
        check("err8",   32'(er1), 32'(me[1]));
        check("hist8",  32'(h1),  pack_hist(1));
`ifdef MODN_SEQ_GRAY_OUT_EN
        check("gray0",  32'(g0),  32'(gray(ms[0])));
        check("gray8",  32'(g1),  32'(gray(ms[1])));
`endif
    endtask

    // Drive one cycle of inputs, clock it, advance the model, then compare.
    task automatic cycle(input logic e, input logic d, input logic c,
                         input logic l, input logic [2:0] v);
        en = e; dir = d; clr = c; load = l; lv = v;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Async reset dropped mid-cycle; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_st0"}, 32'(st0), 32'd0);
        check({tag, "_wr0"}, 32'(wr0), 32'd0);
        check({tag, "_er0"}, 32'(er0), 32'd0);
        check({tag, "_h0"},  32'(h0),  32'd0);
        check({tag, "_st8"}, 32'(st1), 32'd0);
        check({tag, "_h8"},  32'(h1),  32'd0);
`ifdef MODN_SEQ_GRAY_OUT_EN
        check({tag, "_g0"},  32'(g0),  32'd0);
`endif
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int seq1[7];
        int seq2[4];
        en = 0; dir = 0; clr = 0; load = 0; lv = '0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;
        #2;

        // Up-count: 1,2,0,1,2,0,1 with wrap on the 0s.
        seq1 = '{1, 2, 0, 1, 2, 0, 1};
        for (int i = 0; i < 7; i++) begin
            cycle(1, 0, 0, 0, 0);
            check("t1_state", 32'(st0), 32'(seq1[i]));
            check("t1_wrap",  32'(wr0), (seq1[i] == 0) ? 32'd1 : 32'd0);
        end

        // Down-count from 0: 2,1,0,2 with wrap on 0->2.
        cycle(0, 0, 1, 0, 0);
        seq2 = '{2, 1, 0, 2};
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 0, 0);
            check("t2_state", 32'(st0), 32'(seq2[i]));
            check("t2_wrap",  32'(wr0), (seq2[i] == 2) ? 32'd1 : 32'd0);
        end

        // Out-of-range load clamps and flags; in-range load clears the flag.
        cycle(0, 0, 0, 1, 3'd3);
        check("t3_clamp", 32'(st0), 32'd2);
        check("t3_err",   32'(er0), 32'd1);
        cycle(0, 0, 0, 1, 3'd1);
        check("t3_load", 32'(st0), 32'd1);
        check("t3_noerr", 32'(er0), 32'd0);

        // clr beats load and en; history keeps the pre-clear state.
        cycle(1, 0, 1, 1, 3'd2);
        check("t4_state", 32'(st0), 32'd0);
        check("t4_err",   32'(er0), 32'd0);
        check("t4_wrap",  32'(wr0), 32'd0);
        check("t4_hist0", 32'(h0[1:0]), 32'(hist_view(1)));

        // Full-range instance: 7 wraps to 0.
        for (int i = 0; i < 9; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (i == 7) begin
                check("t5_state", 32'(st1), 32'd0);
                check("t5_wrap",  32'(wr1), 32'd1);
            end
        end

        // Async reset at state 2.
        cycle(0, 0, 0, 1, 3'd2);
        check("t6_pre", 32'(st0), 32'd2);
        async_reset("t6");
        check_all();

`ifdef MODN_SEQ_GRAY_OUT_EN
        cycle(1, 0, 0, 0, 0);
        check("t6_g1", 32'(g0), 32'd1);
        cycle(1, 0, 0, 0, 0);
        check("t6_g3", 32'(g0), 32'd3);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7), 1'($urandom),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                  3'($urandom));
            if (i == 200) async_reset("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modn_sequencer.md
Name: modn_sequencer

Overview:
- Parametrised modulo-N state sequencer, the successor to the fixed 2-bit mod-3 enable-gated state machine.
- Adds configurable width, modulus, up/down direction, synchronous clear, parallel load with range checking and a wrap pulse.
- Includes a STAGES-deep registered history line of past states, generalising the fixed 3-register shift chain.
- Sits in the control path; drives phase/slot selection and supplies delayed phase copies to pipelined datapaths.

Parameters:
- WIDTH, 2: bit width of the state value. MODULUS must be at most 2**WIDTH.
- MODULUS, 3: number of states. The sequence runs over 0..MODULUS-1. Must be at least 2.
- STAGES, 3: depth of the history line. Must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance the state by one step this cycle.
- dir  in  1  step direction: 0 counts up, 1 counts down.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- state  out  WIDTH  current state, registered.
- wrap  out  1  registered 1-cycle pulse, asserted while state holds a value just reached by wrap-around.
- load_err  out  1  registered 1-cycle pulse for an out-of-range load.
- hist  out  STAGES*WIDTH  delayed copies of state. Slice k (bits k*WIDTH +: WIDTH) equals state delayed by k+1 cycles.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. Asserting rst_n low immediately forces state=0, wrap=0, load_err=0 and all hist slices=0. Reset takes effect mid-sequence and mid-load. The first active edge after release behaves as normal operation.
- Control priority per edge: clr > load > en > hold.
- clr=1: state<=0. wrap and load_err are 0.
- load=1, clr=0:
  - load_val < MODULUS: state<=load_val, load_err<=0.
  - load_val >= MODULUS: state<=MODULUS-1, load_err<=1.
  - wrap<=0 in both cases.
- en=1, dir=0, no clr/load: state<=state+1. If state==MODULUS-1, state<=0 and wrap<=1.
- en=1, dir=1, no clr/load: state<=state-1. If state==0, state<=MODULUS-1 and wrap<=1.
- en=0, no clr/load: state holds.
- wrap and load_err return to 0 on every edge where their set condition is absent. They never stick.
- Arithmetic: all comparisons are unsigned at WIDTH bits. When MODULUS==2**WIDTH the increment must not rely on natural overflow alone; the explicit terminal compare applies. The state never leaves 0..MODULUS-1.
- History line:
  - Free-running; shifts every edge regardless of en, clr and load.
  - hist slice 0 <= state. Slice k <= slice k-1.
  - clr does not clear history; only rst_n does.
- Latency: control input to state, 1 cycle. state to hist slice k, k+1 cycles.
- Next-state logic is pure combinational with a default assignment (no latches). Registers live in a single always_ff with the async reset in the sensitivity list.

Optional Feature:
- Macro: MODN_SEQ_GRAY_OUT_EN.
- Defined:
  - Adds output port state_gray (WIDTH): Gray code of state, registered in parallel with state, same latency, reset 0.
  - The hist line carries Gray-coded values instead of binary.
- Undefined:
  - state_gray is absent.
  - hist carries binary values.
- state, wrap and load_err are identical in both builds.

Test Plan:
1. Defaults (WIDTH=2, MODULUS=3). Release rst_n, hold en=1, dir=0 for 7 cycles -> state 1,2,0,1,2,0,1. wrap high exactly on the cycles where state shows 0. hist slice 2 shows the same sequence 3 cycles later.
2. Defaults. dir=1, en=1 starting from 0 -> state 2,1,0,2. wrap high on each transition 0->2.
3. Defaults. load=1, load_val=3 -> state=2 and load_err=1 for one cycle. Then load_val=1 -> state=1, load_err=0.
4. Same edge: clr=1, load=1, load_val=2, en=1 -> state=0, load_err=0, wrap=0. hist is not cleared; slice 0 holds the pre-clear state.
5. WIDTH=3, MODULUS=8 counting up -> 7 wraps to 0 with wrap=1; state never reads X.
6. Drop rst_n asynchronously mid-cycle at state=2 -> state, wrap, load_err and hist go to 0 before the next clk edge. With MODN_SEQ_GRAY_OUT_EN defined, up-count 0..2 yields state_gray 0,1,3.
